// File: rtl/h14rx_decoder.sv
// h14rx_decoder: TMDS channel receiver. Classifies each 10-bit symbol as control,
// guard or video, decodes it with one cycle latency and aligns words via bitslip.
module h14rx_decoder #(
    parameter int Chan         = 0,
    parameter int WindowLen    = 2048,
    parameter int CtlThreshold = 64,
    parameter int SlipWait     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] symbol,
    output logic       bitslip,
    output logic       locked,
    output logic       de,
    output logic       guard,
    output logic [1:0] ctl,
    output logic [7:0] video
);

    localparam logic [1:0] S_SEARCH = 2'd0;
    localparam logic [1:0] S_SLIP   = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;

    localparam logic [9:0]  GUARD_CODE = (Chan == 1) ? 10'b0100110011 : 10'b1011001100;
    localparam logic [11:0] WIN_LAST   = 12'(WindowLen - 1);
    localparam logic [11:0] CTL_THR    = 12'(CtlThreshold);
    localparam logic [7:0]  SLIP_LAST  = 8'(SlipWait);

    logic [1:0]  state_q, state_d;
    logic [11:0] win_cnt_q, win_cnt_d;
    logic [11:0] ctl_cnt_q, ctl_cnt_d, ctl_cnt_inc;
    logic [7:0]  slip_cnt_q, slip_cnt_d;
    logic        bitslip_q, bitslip_d;
    logic        prev_cg_q, prev_cg_d;
    logic        de_q, de_d;
    logic        guard_q, guard_d;
    logic [1:0]  ctl_q, ctl_d;
    logic [7:0]  video_q, video_d;

    logic        is_ctl, is_guard, is_video;
    logic [1:0]  ctl_code;
    logic [7:0]  dbits, vbyte;

    always_comb begin : classify
        is_ctl   = 1'b1;
        ctl_code = 2'b00;
        case (symbol)
            10'b1101010100: ctl_code = 2'b00;
            10'b0010101011: ctl_code = 2'b01;
            10'b0101010100: ctl_code = 2'b10;
            10'b1010101011: ctl_code = 2'b11;
            default:        is_ctl   = 1'b0;
        endcase
        // A guard pattern only counts as guard when it follows control/guard.
        is_guard = !is_ctl && (symbol == GUARD_CODE) && prev_cg_q;
        is_video = !is_ctl && !is_guard;
    end

    always_comb begin : video_decode
        dbits    = symbol[9] ? ~symbol[7:0] : symbol[7:0];
        vbyte    = '0;
        vbyte[0] = dbits[0];
        for (int unsigned i = 1; i < 8; i++) begin
            vbyte[i] = symbol[8] ? (dbits[i] ^ dbits[i-1]) : ~(dbits[i] ^ dbits[i-1]);
        end
    end

    always_comb begin : decode_next
        prev_cg_d = is_ctl || is_guard;
        de_d      = is_video;
        guard_d   = is_guard;
        ctl_d     = is_ctl ? ctl_code : ctl_q;
        video_d   = is_video ? vbyte : video_q;
    end

    always_comb begin : align_fsm
        state_d     = state_q;
        win_cnt_d   = win_cnt_q;
        ctl_cnt_d   = ctl_cnt_q;
        slip_cnt_d  = slip_cnt_q;
        bitslip_d   = 1'b0;
        ctl_cnt_inc = (is_ctl && (ctl_cnt_q != CTL_THR)) ? ctl_cnt_q + 12'd1 : ctl_cnt_q;
        case (state_q)
            S_SEARCH: begin
                if (ctl_cnt_inc == CTL_THR) begin
                    state_d   = S_LOCKED;
                    win_cnt_d = '0;
                    ctl_cnt_d = '0;
                end else if (win_cnt_q == WIN_LAST) begin
                    state_d    = S_SLIP;
                    bitslip_d  = 1'b1;
                    slip_cnt_d = '0;
                    win_cnt_d  = '0;
                    ctl_cnt_d  = '0;
                end else begin
                    win_cnt_d = win_cnt_q + 12'd1;
                    ctl_cnt_d = ctl_cnt_inc;
                end
            end
            S_SLIP: begin
                // Pulse cycle at count 0, then SlipWait quiet cycles.
                if (slip_cnt_q == SLIP_LAST) begin
                    state_d    = S_SEARCH;
                    slip_cnt_d = '0;
                    win_cnt_d  = '0;
                    ctl_cnt_d  = '0;
                end else begin
                    slip_cnt_d = slip_cnt_q + 8'd1;
                end
            end
            S_LOCKED: begin
                if (win_cnt_q == WIN_LAST) begin
                    win_cnt_d = '0;
                    ctl_cnt_d = '0;
                    if (ctl_cnt_inc == '0) begin
                        state_d = S_SEARCH;
                    end
                end else begin
                    win_cnt_d = win_cnt_q + 12'd1;
                    ctl_cnt_d = ctl_cnt_inc;
                end
            end
            default: begin
                state_d    = S_SEARCH;
                win_cnt_d  = '0;
                ctl_cnt_d  = '0;
                slip_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_SEARCH;
            win_cnt_q  <= '0;
            ctl_cnt_q  <= '0;
            slip_cnt_q <= '0;
            bitslip_q  <= 1'b0;
            prev_cg_q  <= 1'b0;
            de_q       <= 1'b0;
            guard_q    <= 1'b0;
            ctl_q      <= '0;
            video_q    <= '0;
        end else begin
            state_q    <= state_d;
            win_cnt_q  <= win_cnt_d;
            ctl_cnt_q  <= ctl_cnt_d;
            slip_cnt_q <= slip_cnt_d;
            bitslip_q  <= bitslip_d;
            prev_cg_q  <= prev_cg_d;
            de_q       <= de_d;
            guard_q    <= guard_d;
            ctl_q      <= ctl_d;
            video_q    <= video_d;
        end
    end

    assign locked  = (state_q == S_LOCKED);
    assign bitslip = bitslip_q;
    assign de      = locked & de_q;
    assign guard   = locked & guard_q;
    assign ctl     = locked ? ctl_q : 2'b00;
    assign video   = locked ? video_q : 8'h00;

endmodule

// File: tb/tb_h14rx_decoder.sv
// Self-checking bench for h14rx_decoder: directed tables and sequences plus
// randomized traffic compared against a symbol-level behavioural model.
module tb_h14rx_decoder;

    localparam int WIN   = 256;
    localparam int THR   = 64;
    localparam int SLIPW = 16;
    localparam logic [9:0] GUARD_SYM = 10'b1011001100;
    localparam logic [9:0] CTL0      = 10'b1101010100;

    logic       clk;
    logic       rst;
    logic [9:0] symbol;
    logic       bitslip, locked, de, guard;
    logic [1:0] ctl;
    logic [7:0] video;

    h14rx_decoder #(
        .Chan(0),
        .WindowLen(WIN),
        .CtlThreshold(THR),
        .SlipWait(SLIPW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .symbol(symbol),
        .bitslip(bitslip),
        .locked(locked),
        .de(de),
        .guard(guard),
        .ctl(ctl),
        .video(video)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int enc_cnt = 0;
    int step_no = 0;

    logic [9:0] ctl_codes [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

    // Behavioural model state
    string      m_mode;
    int         m_seen, m_ctrls, m_quiet;
    bit         m_prev_cg, m_de, m_guard, exp_bitslip;
    logic [1:0] m_ctl;
    logic [7:0] m_video;

    // Deserializer model
    bit sq[$];
    int sidx;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    function automatic logic [9:0] tmds_enc(input logic [7:0] d);
        logic [8:0] qm;
        logic [9:0] q;
        int n1, n0;
        n1 = $countones(d);
        qm[0] = d[0];
        if (n1 > 4 || (n1 == 4 && !d[0])) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
            qm[8] = 1'b1;
        end
        n1 = $countones(qm[7:0]);
        n0 = 8 - n1;
        if (enc_cnt == 0 || n1 == n0) begin
            q = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            enc_cnt += qm[8] ? (n1 - n0) : (n0 - n1);
        end else if ((enc_cnt > 0 && n1 > n0) || (enc_cnt < 0 && n0 > n1)) begin
            q = {1'b1, qm[8], ~qm[7:0]};
            enc_cnt += 2 * int'(qm[8]) + (n0 - n1);
        end else begin
            q = {1'b0, qm[8], qm[7:0]};
            enc_cnt += -2 * int'(!qm[8]) + (n1 - n0);
        end
        return q;
    endfunction

    function automatic logic [7:0] tmds_dec(input logic [9:0] s);
        logic [7:0] d, v;
        d = s[9] ? ~s[7:0] : s[7:0];
        v[0] = d[0];
        for (int i = 1; i < 8; i++) v[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        return v;
    endfunction

    task automatic model_reset();
        m_mode = "SEARCH";
        m_seen = 0; m_ctrls = 0; m_quiet = 0;
        m_prev_cg = 1'b0; m_de = 1'b0; m_guard = 1'b0; exp_bitslip = 1'b0;
        m_ctl = 2'b00; m_video = 8'h00;
    endtask

    task automatic model_step(input logic [9:0] s);
        bit is_c, is_g;
        logic [1:0] cv;
        is_c = 1'b0;
        cv = 2'b00;
        for (int k = 0; k < 4; k++) begin
            if (s == ctl_codes[k]) begin
                is_c = 1'b1;
                cv = 2'(k);
            end
        end
        is_g = !is_c && (s == GUARD_SYM) && m_prev_cg;
        m_prev_cg = is_c || is_g;
        m_de = !is_c && !is_g;
        m_guard = is_g;
        if (is_c) m_ctl = cv;
        if (m_de) m_video = tmds_dec(s);
        exp_bitslip = 1'b0;
        if (m_mode == "SEARCH") begin
            m_seen++;
            if (is_c) m_ctrls++;
            if (m_ctrls >= THR) begin
                m_mode = "LOCKED"; m_seen = 0; m_ctrls = 0;
            end else if (m_seen == WIN) begin
                m_mode = "SLIP"; exp_bitslip = 1'b1; m_quiet = SLIPW;
            end
        end else if (m_mode == "SLIP") begin
            if (m_quiet == 0) begin
                m_mode = "SEARCH"; m_seen = 0; m_ctrls = 0;
            end else begin
                m_quiet--;
            end
        end else begin
            m_seen++;
            if (is_c) m_ctrls++;
            if (m_seen == WIN) begin
                if (m_ctrls == 0) m_mode = "SEARCH";
                m_seen = 0; m_ctrls = 0;
            end
        end
    endtask

    task automatic step(input logic [9:0] s);
        bit lk;
        symbol = s;
        model_step(s);
        @(posedge clk);
        #1;
        step_no++;
        lk = (m_mode == "LOCKED");
        chk($sformatf("s%0d.bitslip", step_no), int'(bitslip), int'(exp_bitslip));
        chk($sformatf("s%0d.locked", step_no), int'(locked), int'(lk));
        chk($sformatf("s%0d.de", step_no), int'(de), int'(lk & m_de));
        chk($sformatf("s%0d.guard", step_no), int'(guard), int'(lk & m_guard));
        chk($sformatf("s%0d.ctl", step_no), int'(ctl), lk ? int'(m_ctl) : 0);
        chk($sformatf("s%0d.video", step_no), int'(video), lk ? int'(m_video) : 0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst.bitslip", int'(bitslip), 0);
        chk("rst.locked", int'(locked), 0);
        chk("rst.de", int'(de), 0);
        chk("rst.guard", int'(guard), 0);
        chk("rst.ctl", int'(ctl), 0);
        chk("rst.video", int'(video), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic next_word(output logic [9:0] w);
        logic [9:0] s;
        while (sq.size() < 20) begin
            s = (sidx % 32 < 20) ? CTL0 : tmds_enc(8'(sidx));
            sidx++;
            for (int b = 0; b < 10; b++) sq.push_back(s[b]);
        end
        for (int b = 0; b < 10; b++) w[b] = sq.pop_front();
    endtask

    typedef struct {
        logic [9:0] sym;
        bit         enc;
        logic [7:0] dat;
        bit         exp_de;
        bit         exp_guard;
        logic [1:0] exp_ctl;
        bit         chk_vid;
        logic [7:0] exp_vid;
    } vec_t;

    vec_t tbl [12];

    initial begin
        logic [9:0] w;
        bit dummy;
        int slips, prev_at, pc, r, pick;
        bit lost, got;

        tbl[0]  = '{10'b0010101011, 1'b0, 8'h00, 1'b0, 1'b0, 2'b01, 1'b0, 8'h00};
        tbl[1]  = '{GUARD_SYM,      1'b0, 8'h00, 1'b0, 1'b1, 2'b01, 1'b0, 8'h00};
        tbl[2]  = '{10'b0,          1'b1, 8'h00, 1'b1, 1'b0, 2'b01, 1'b1, 8'h00};
        tbl[3]  = '{10'b0,          1'b1, 8'hFF, 1'b1, 1'b0, 2'b01, 1'b1, 8'hFF};
        tbl[4]  = '{10'b0,          1'b1, 8'h10, 1'b1, 1'b0, 2'b01, 1'b1, 8'h10};
        tbl[5]  = '{10'b0,          1'b1, 8'hA5, 1'b1, 1'b0, 2'b01, 1'b1, 8'hA5};
        tbl[6]  = '{GUARD_SYM,      1'b0, 8'h00, 1'b1, 1'b0, 2'b01, 1'b1, 8'hAB};
        tbl[7]  = '{10'b1010101011, 1'b0, 8'h00, 1'b0, 1'b0, 2'b11, 1'b1, 8'hAB};
        tbl[8]  = '{10'b0101010100, 1'b0, 8'h00, 1'b0, 1'b0, 2'b10, 1'b1, 8'hAB};
        tbl[9]  = '{GUARD_SYM,      1'b0, 8'h00, 1'b0, 1'b1, 2'b10, 1'b1, 8'hAB};
        tbl[10] = '{10'b0,          1'b1, 8'h5A, 1'b1, 1'b0, 2'b10, 1'b1, 8'h5A};
        tbl[11] = '{CTL0,           1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b1, 8'h5A};

        rst = 1'b0;
        symbol = '0;
        #2;
        apply_reset();

        // Aligned control stream: lock on the cycle after the 64th control
        slips = 0;
        for (int i = 1; i <= 300; i++) begin
            step(CTL0);
            slips += int'(bitslip);
            if (i == THR - 1) chk("lock.before", int'(locked), 0);
            if (i == THR) chk("lock.at_thr", int'(locked), 1);
        end
        chk("lock.no_bitslip", slips, 0);

        enc_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            w = tbl[i].enc ? tmds_enc(tbl[i].dat) : tbl[i].sym;
            step(w);
            chk($sformatf("tbl%0d.de", i), int'(de), int'(tbl[i].exp_de));
            chk($sformatf("tbl%0d.guard", i), int'(guard), int'(tbl[i].exp_guard));
            chk($sformatf("tbl%0d.ctl", i), int'(ctl), int'(tbl[i].exp_ctl));
            if (tbl[i].chk_vid) chk($sformatf("tbl%0d.video", i), int'(video), int'(tbl[i].exp_vid));
        end

        // Loss of lock after a window without control symbols
        lost = 1'b0;
        slips = 0;
        for (int i = 0; i < 2 * WIN + 8 && !lost; i++) begin
            step(tmds_enc(8'(i * 7 + 3)));
            slips += int'(bitslip);
            if (!locked) lost = 1'b1;
        end
        chk("unlock.locked", int'(locked), 0);
        chk("unlock.de", int'(de), 0);
        chk("unlock.ctl", int'(ctl), 0);
        chk("unlock.no_bitslip", slips, 0);

        got = 1'b0;
        for (int i = 0; i < WIN + 8 && !got; i++) begin
            step(tmds_enc(8'(i + 40)));
            if (bitslip) got = 1'b1;
        end
        chk("slip.seen", int'(bitslip), 1);
        #2;
        apply_reset();
        slips = 0;
        for (int i = 0; i < WIN - 1; i++) begin
            step(tmds_enc(8'h3C));
            slips += int'(bitslip);
        end
        chk("post_rst.quiet", slips, 0);
        step(tmds_enc(8'h3C));
        chk("post_rst.slip_at_window", int'(bitslip), 1);

        // Deserializer misaligned by 3 bits, honoring bitslip
        apply_reset();
        sq.delete();
        sidx = 0;
        enc_cnt = 0;
        next_word(w);
        for (int b = 0; b < 7; b++) dummy = sq.pop_front();
        slips = 0;
        prev_at = 0;
        for (int i = 1; i <= 3000 && !locked; i++) begin
            next_word(w);
            step(w);
            if (bitslip) begin
                if (slips == 0) chk("align.first_slip", i, WIN);
                else chk($sformatf("align.gap%0d", slips), i - prev_at, 1 + SLIPW + WIN);
                prev_at = i;
                slips++;
                next_word(w);
                for (int b = 9; b >= 0; b--) sq.push_front(w[b]);
                dummy = sq.pop_front();
            end
        end
        chk("align.slip_count", slips, 3);
        chk("align.locked", int'(locked), 1);

        // Randomized traffic with varying control density
        apply_reset();
        for (int seg = 0; seg < 12; seg++) begin
            pick = $urandom_range(2);
            pc = (pick == 0) ? 45 : (pick == 1) ? 8 : 0;
            if (seg == 6) apply_reset();
            for (int n = 0; n < 300; n++) begin
                r = $urandom_range(99);
                if (r < pc) w = ctl_codes[$urandom_range(3)];
                else if (r < pc + 12) w = GUARD_SYM;
                else if (r < pc + 60) w = tmds_enc(8'($urandom));
                else w = 10'($urandom);
                step(w);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/h14rx_decoder.md
H14RX_DECODER -- requirements
Module: h14rx_decoder

Interface
REQ-001 Parameter Chan, default 0, TMDS channel index (0..2) that selects the guard-band code.
REQ-002 Parameter WindowLen, default 2048, observation window in symbols; legal range 16..4095.
REQ-003 Parameter CtlThreshold, default 64, minimum control symbols per window to declare lock; legal range 1..WindowLen.
REQ-004 Parameter SlipWait, default 16, settle cycles after a bitslip pulse; legal range 1..255.
REQ-005 clk  input  1  symbol clock; all logic is on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 symbol  input  10  raw deserialized word, sampled every cycle; bit 0 is the first bit on the wire.
REQ-008 bitslip  output  1  one-cycle pulse asking the deserializer to shift word alignment by 1 bit.
REQ-009 locked  output  1  word alignment achieved.
REQ-010 de  output  1  video data valid.
REQ-011 guard  output  1  video guard-band symbol received.
REQ-012 ctl  output  2  decoded control bits {c1,c0}.
REQ-013 video  output  8  decoded video byte.

Function
REQ-014 Control codes SHALL be decoded as follows:
- 1101010100 -> 00
- 0010101011 -> 01
- 0101010100 -> 10
- 1010101011 -> 11
REQ-015 Guard code SHALL be 1011001100 for Chan 0 and Chan 2, and 0100110011 for Chan 1.
REQ-016 Symbol classification per cycle: control if the symbol matches a control code; else guard if it matches the guard code and the previous classified symbol was control or guard; else video.
REQ-017 Video decode steps:
- d = symbol[9] ? ~symbol[7:0] : symbol[7:0]
- video[0] = d[0]
- for i = 1..7: video[i] = symbol[8] ? d[i]^d[i-1] : d[i]~^d[i-1]
REQ-018 All of de, guard, ctl and video SHALL be registered with exactly 1 cycle latency from symbol.
REQ-019 A control symbol SHALL update ctl; ctl SHALL hold its last control value through guard and video symbols.
REQ-020 video SHALL update only on video symbols and hold otherwise.
REQ-021 de SHALL be 1 only for video symbols; guard SHALL be 1 only for guard symbols; at most one of de and guard is high in any cycle.
REQ-022 While locked=0, the outputs SHALL be forced: de=0, guard=0, ctl=00, video=00h.
REQ-023 The alignment FSM has three states: SEARCH, SLIP, LOCKED.
REQ-024 SEARCH behaviour:
- a window counter counts WindowLen symbols, and a control counter (saturating at CtlThreshold) counts control symbols;
- when the control counter reaches CtlThreshold, go to LOCKED on the next cycle;
- else at window end, pulse bitslip for 1 cycle and go to SLIP.
REQ-025 SLIP SHALL wait SlipWait cycles with bitslip=0 and symbols ignored, then enter SEARCH with both counters cleared.
REQ-026 LOCKED behaviour:
- locked=1 from the first cycle in LOCKED;
- windows of WindowLen symbols are counted;
- a window with zero control symbols SHALL set locked=0, enter SEARCH with counters cleared, and not pulse bitslip.
REQ-027 Entering LOCKED in mid-window SHALL restart the window counter at 0.
REQ-028 Counter widths: window 12 bits, control 12 bits, slip 8 bits; no wrap-around is permitted within the legal parameter ranges.
REQ-029 The guard-classification history SHALL track classification regardless of lock state.

Reset
REQ-030 While rst=1, the block SHALL hold:
- FSM in SEARCH with all counters at 0;
- bitslip=0, locked=0, de=0, guard=0, ctl=00, video=00h;
- guard history cleared to "previous was video".
REQ-031 An asserted rst mid-operation (any state) SHALL take effect immediately (asynchronous); the first decision after release is made with WindowLen symbols counted from release.

Verification
REQ-032 The bench SHALL cover the following directed scenarios:
- Aligned stream: 300 x 1101010100 then video, WindowLen=256, CtlThreshold=64 -> locked rises on the cycle after the 64th control symbol; no bitslip.
- Misaligned by 3 bits, with the deserializer model honoring bitslip -> exactly 3 bitslip pulses, each followed by SlipWait quiet cycles, then locked=1.
- Locked: control 0010101011 -> ctl=01 one cycle later; then the Chan-0 guard code 1011001100 -> guard=1, de=0, ctl held at 01.
- Locked: video symbols from the TMDS encoder for bytes 00h, FFh, 10h, A5h with running disparity -> de=1 and video equals each byte, 1 cycle later.
- Guard code 1011001100 directly after a video symbol -> classified as video (de=1), guard=0.
- Locked, then WindowLen symbols with no control code -> locked=0, de=0, ctl=00, no bitslip; rst pulsed mid-SLIP -> all outputs 0 asynchronously, FSM in SEARCH.
